n_bit_seq_alu: RTL and testbench

Parametrised, registered successor to the single-cycle n-bit ALU. It sits in the execute stage and adds several things: a valid/ready handshake on both sides, a registered result, an extended opcode set (XOR, shifts, set-less-than), an iterative shift-add multiplier, and full N/Z/C/V flags with correct signed overflow for both add and subtract. One operation is in flight at a time; the result is held until the consumer takes it.

---
 rtl/n_bit_seq_alu.sv | 146 ++++++++++++++
 tb/tb_n_bit_seq_alu.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n_bit_seq_alu.sv
// Registered execute-stage ALU with valid/ready handshakes on both sides.
// One operation in flight; MUL/MULHU iterate one shift-add step per cycle.
module n_bit_seq_alu #(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic [3:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] ALUout,
  output logic         zFlag,
  output logic         nFlag,
  output logic         cFlag,
  output logic         ofFlag
);

  localparam int unsigned SW = $clog2(n);
  localparam int unsigned CW = $clog2(n) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [2*n-1:0]  prod;
  logic [n-1:0]    mplier;
  logic [n-1:0]    mcand;
  logic            hi_sel;
  logic [CW-1:0]   count;

  logic            sub;
  logic [n-1:0]    beff;
  logic [n-1:0]    sum;
  logic            carry;
  logic [SW-1:0]   shamt;
  logic [n-1:0]    alu_res;
  logic            alu_c;
  logic            alu_v;

  always_comb begin
    sub   = (sel == 4'b0110);
    beff  = sub ? ~B : B;
    {carry, sum} = {1'b0, A} + {1'b0, beff} + {{n{1'b0}}, sub};
    shamt = B[SW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (sel)
      4'b0000: alu_res = A & B;
      4'b0001: alu_res = A | B;
      4'b0011: alu_res = A ^ B;
      4'b0010, 4'b0110: begin
        alu_res = sum;
        alu_c   = carry;
        alu_v   = (A[n-1] == beff[n-1]) && (sum[n-1] != A[n-1]);
      end
      4'b0100: alu_res = A << shamt;
      4'b0101: alu_res = A >> shamt;
      4'b0111: alu_res = $unsigned($signed(A) >>> shamt);
      4'b1000: alu_res = {{(n-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b1001: alu_res = {{(n-1){1'b0}}, (A < B)};
      default: alu_res = '0;
    endcase
  end

  // Right-shifting shift-add: the high half accumulates, the low half collects retired bits.
  logic [n-1:0]   addend;
  logic [n:0]     step_sum;
  logic [2*n-1:0] prod_next;
  logic [n-1:0]   mul_res;

  always_comb begin
    addend    = mplier[0] ? mcand : '0;
    step_sum  = {1'b0, prod[2*n-1:n]} + {1'b0, addend};
    prod_next = {step_sum, prod[n-1:1]};
    mul_res   = hi_sel ? prod_next[2*n-1:n] : prod_next[n-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ALUout    <= '0;
      zFlag     <= 1'b0;
      nFlag     <= 1'b0;
      cFlag     <= 1'b0;
      ofFlag    <= 1'b0;
      prod      <= '0;
      mplier    <= '0;
      mcand     <= '0;
      hi_sel    <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (sel == 4'b1010 || sel == 4'b1011) begin
              mcand  <= A;
              mplier <= B;
              hi_sel <= sel[0];
              prod   <= '0;
              count  <= CW'(n);
              state  <= BUSY;
            end else begin
              ALUout    <= alu_res;
              zFlag     <= (alu_res == '0);
              nFlag     <= alu_res[n-1];
              cFlag     <= alu_c;
              ofFlag    <= alu_v;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          prod   <= prod_next;
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
          if (count == CW'(1)) begin
            ALUout    <= mul_res;
            zFlag     <= (mul_res == '0);
            nFlag     <= mul_res[n-1];
            cFlag     <= 1'b0;
            ofFlag    <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n_bit_seq_alu.sv
// Directed-vector bench for n_bit_seq_alu (n=32) with an arithmetic reference model
// and a per-cycle monitor checking results, flags, latency and handshakes.
module tb_n_bit_seq_alu;

  localparam int unsigned N = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic [3:0]    sel;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  ALUout;
  logic          zFlag;
  logic          nFlag;
  logic          cFlag;
  logic          ofFlag;

  n_bit_seq_alu #(.n(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .ALUout(ALUout), .zFlag(zFlag), .nFlag(nFlag), .cFlag(cFlag), .ofFlag(ofFlag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } res_t;

  typedef struct {
    res_t e;
    int   acc;
    bit   mul;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   new_out = 1'b1;
  bit   popped_prev = 1'b0;
  exp_t q[$];

  // Reference: true integer arithmetic; overflow means the exact signed result is not representable.
  function automatic res_t model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    res_t        m;
    longint      d;
    logic [63:0] p;
    int          sh;
    m  = '0;
    sh = int'(b[4:0]);
    p  = 64'(a) * 64'(b);
    case (s)
      4'd0:  m.r = a & b;
      4'd1:  m.r = a | b;
      4'd2: begin
        m.r = a + b;
        m.c = (64'(a) + 64'(b)) >= 64'h1_0000_0000;
        d   = longint'($signed(a)) + longint'($signed(b));
        m.v = (d != longint'($signed(m.r)));
      end
      4'd3:  m.r = a ^ b;
      4'd4:  m.r = a << sh;
      4'd5:  m.r = a >> sh;
      4'd6: begin
        m.r = a - b;
        m.c = (a >= b);
        d   = longint'($signed(a)) - longint'($signed(b));
        m.v = (d != longint'($signed(m.r)));
      end
      4'd7:  m.r = $signed(a) >>> sh;
      4'd8:  m.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  m.r = (a < b) ? 32'd1 : 32'd0;
      4'd10: m.r = p[31:0];
      4'd11: m.r = p[63:32];
      default: m.r = '0;
    endcase
    m.z = (m.r == 0);
    m.n = m.r[31];
    return m;
  endfunction

  task automatic monitor();
    res_t got;
    int   lat;
    int   want_lat;
    forever begin
      @(negedge clk);
      cyc++;
      got = {ALUout, zFlag, nFlag, cFlag, ofFlag};
      if (rst) begin
        q.delete();
        new_out = 1'b1;
        popped_prev = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || got !== '0) begin
          errors++;
          $display("FAIL reset_state got out_valid=%b res=%h want out_valid=0 res=0", out_valid, got);
        end
      end else begin
        if (popped_prev) begin
          checks++;
          if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_return got in_ready=%b want 1", in_ready);
          end
        end
        popped_prev = 1'b0;
        if (q.size() > 0) begin
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_busy cyc=%0d got %b want 0", cyc, in_ready);
          end
        end
        if (out_valid === 1'b1) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out_valid cyc=%0d got 1 want 0", cyc);
          end else begin
            checks++;
            if (got !== q[0].e) begin
              errors++;
              $display("FAIL result cyc=%0d got r=%h zncv=%b want r=%h zncv=%b",
                       cyc, got.r, {got.z, got.n, got.c, got.v},
                       q[0].e.r, {q[0].e.z, q[0].e.n, q[0].e.c, q[0].e.v});
            end
            if (new_out) begin
              lat = cyc - q[0].acc;
              want_lat = q[0].mul ? N + 1 : 1;
              checks++;
              if (lat != want_lat) begin
                errors++;
                $display("FAIL latency got %0d want %0d", lat, want_lat);
              end
              new_out = 1'b0;
            end
            if (out_ready === 1'b1) begin
              void'(q.pop_front());
              new_out = 1'b1;
              popped_prev = 1'b1;
            end
          end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1)
          q.push_back('{e: model(sel, A, B), acc: cyc, mul: (sel == 4'd10 || sel == 4'd11)});
      end
    end
  endtask

  task automatic wait_ready(input string what);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_%s got in_ready=%b want 1", what, in_ready);
    end
  endtask

  // Called at posedge+1; pins the model to a hand-computed literal, then issues the op.
  task automatic issue(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef, input bit wait_done);
    res_t m;
    m = model(s, a, b);
    checks++;
    if (m !== {er, ef}) begin
      errors++;
      $display("FAIL model_pin sel=%b got %h/%b want %h/%b", s, m.r, {m.z, m.n, m.c, m.v}, er, ef);
    end
    wait_ready("accept");
    sel = s;
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = $urandom();
    B = $urandom();
    sel = 4'hF;
    if (wait_done) wait_ready("done");
  endtask

  task automatic check_now(input string what, input logic [39:0] got, input logic [39:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", what, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    sel = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_now("ready_after_reset", 40'(in_ready), 40'd1);

    //    sel    A             B             result        zncv
    issue(4'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 1'b1);
    issue(4'd6, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 1'b1);
    issue(4'd6, 32'd5,        32'd5,        32'h00000000, 4'b1010, 1'b1);
    issue(4'd7, 32'h80000000, 32'd36,       32'hF8000000, 4'b0100, 1'b1);
    issue(4'd5, 32'h80000000, 32'd36,       32'h08000000, 4'b0000, 1'b1);
    issue(4'd8, 32'hFFFFFFFF, 32'd1,        32'h00000001, 4'b0000, 1'b1);
    issue(4'd9, 32'hFFFFFFFF, 32'd1,        32'h00000000, 4'b1000, 1'b1);
    issue(4'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100, 1'b1);
    issue(4'd1, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000, 1'b1);
    issue(4'd4, 32'h00000001, 32'd31,       32'h80000000, 4'b0100, 1'b1);
    issue(4'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 1'b1);
    issue(4'd6, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 4'b0100, 1'b1);
    issue(4'd12, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b1000, 1'b1);
    issue(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 1'b1);
    issue(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 1'b1);
    issue(4'd10, 32'h00010000, 32'h00010000, 32'h00000000, 4'b1000, 1'b1);
    issue(4'd11, 32'h00010000, 32'h00010003, 32'h00000001, 4'b0000, 1'b1);

    // Backpressure: result must hold while a competing request is offered.
    out_ready = 1'b0;
    issue(4'd3, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 4'b0000, 1'b0);
    sel = 4'd2;
    A = 32'd1;
    B = 32'd1;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_ready("xor_release");

    // Asynchronous reset mid-cycle while a result is held.
    out_ready = 1'b0;
    issue(4'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_now("async_reset_outputs", {ALUout, zFlag, nFlag, cFlag, ofFlag, out_valid, 3'b0}, 40'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check_now("ready_after_async_reset", 40'(in_ready), 40'd1);

    // Reset ten cycles into a multiply: no result may appear for it.
    issue(4'd10, 32'h00001234, 32'h00005678, 32'h06260060, 4'b0000, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_now("mul_abort_outputs", {ALUout, zFlag, nFlag, cFlag, ofFlag, out_valid, 3'b0}, 40'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    issue(4'd2, 32'd2, 32'd3, 32'd5, 4'b0000, 1'b1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
